// File: rtl/mul_div_unit.sv
// mul_div_unit: MIPS execute-stage multiply/divide unit with HI/LO registers.
// Signed ops work on magnitudes and fix the sign at commit. A restoring divider
// produces one quotient bit per cycle. A later-stage cancel aborts the operation
// in flight without writing HI/LO.
// Optional feature macro: MD_MUL_PIPE_EN. When it is defined, the product goes
// through MUL_STAGES register stages. When it is undefined, a single-cycle
// multiply is used.
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MD_MUL_PIPE_EN
    localparam int MUL_LAT = MUL_STAGES;
`else
    localparam int MUL_LAT = 1;
`endif
    // Wide enough for both the divide iteration count and the multiply stage count.
    localparam int CW = $clog2(WIDTH + MUL_STAGES + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  quo_q;      // dividend magnitude, shifted into a quotient while dividing
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  b_q;        // divisor / multiplier magnitude
    logic [WIDTH-1:0]  src1_q;     // raw src1, returned in HI on divide by zero
    logic              neg_q;      // operand signs differ (signed ops only)
    logic              rneg_q;     // dividend negative (signed ops only)
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              dbz_q, dbz_d, done_q, done_d;

    logic              accept, is_mul, is_div, sgn, s1_neg, s2_neg;
    logic [WIDTH-1:0]  mag1, mag2;
    logic              mul_last, div_last;
    logic [2*WIDTH-1:0] mul_mag, mul_res;
    logic [WIDTH:0]    rem_sh;
    logic              ge;
    logic [WIDTH-1:0]  diff, rem_nxt, quo_nxt, quo_fix, rem_fix;

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    assign accept = req_valid && req_ready && !cancel;
    assign is_mul = (req_op[2:1] == 2'b00);
    assign is_div = (req_op[2:1] == 2'b01);
    assign sgn    = !req_op[0];
    assign s1_neg = sgn && req_src1[WIDTH-1];
    assign s2_neg = sgn && req_src2[WIDTH-1];
    assign mag1   = s1_neg ? -req_src1 : req_src1;
    assign mag2   = s2_neg ? -req_src2 : req_src2;

    assign mul_last = (cnt_q == CW'(MUL_LAT - 1));
    assign div_last = (cnt_q == CW'(WIDTH - 1));

`ifdef MD_MUL_PIPE_EN
    logic [2*WIDTH-1:0] pipe_q [MUL_STAGES];

    // Free-running product pipe fed from the request magnitudes. The accept-cycle
    // product reaches the last stage exactly when the counter expires.
    always_ff @(posedge clk) begin
        pipe_q[0] <= {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
        for (int k = 1; k < MUL_STAGES; k++) pipe_q[k] <= pipe_q[k-1];
    end
    assign mul_mag = pipe_q[MUL_STAGES-1];
`else
    assign mul_mag = {{WIDTH{1'b0}}, quo_q} * {{WIDTH{1'b0}}, b_q};
`endif
    assign mul_res = neg_q ? -mul_mag : mul_mag;

    // Restoring step: shift the next dividend bit in and subtract if it fits.
    // When it fits, the true difference is below the divisor, so WIDTH bits are enough.
    assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
    assign ge      = (rem_sh >= {1'b0, b_q});
    assign diff    = rem_sh[WIDTH-1:0] - b_q;
    assign rem_nxt = ge ? diff : rem_sh[WIDTH-1:0];
    assign quo_nxt = {quo_q[WIDTH-2:0], ge};
    assign quo_fix = neg_q  ? -quo_q : quo_q;
    assign rem_fix = rneg_q ? -rem_q : rem_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic. Cancel overrides everything and returns the unit to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul)      state_d = S_MUL;
                else if (accept && is_div) state_d = S_DIV;
            end
            S_MUL:   if (mul_last) state_d = S_IDLE;
            S_DIV:   if (div_last) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (cancel) state_d = S_IDLE;
    end

    // Architectural commit: HI/LO, the zero-divisor flag and the done pulse.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        dbz_d  = dbz_q;
        done_d = 1'b0;
        if (!cancel) begin
            case (state_q)
                S_IDLE: begin
                    if (accept && req_op == 3'b100) begin
                        hi_d = req_src1; done_d = 1'b1;
                    end else if (accept && req_op == 3'b101) begin
                        lo_d = req_src1; done_d = 1'b1;
                    end
                end
                S_MUL: begin
                    if (mul_last) begin
                        {hi_d, lo_d} = mul_res;
                        done_d       = 1'b1;
                    end
                end
                S_FIX: begin
                    done_d = 1'b1;
                    if (b_q == '0) begin
                        lo_d  = '1;
                        hi_d  = src1_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d  = quo_fix;
                        hi_d  = rem_fix;
                        dbz_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dbz_q  <= dbz_d;
            done_q <= done_d;
        end
    end

    // Operand capture on accept, then the iteration counter and divider datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            b_q    <= '0;
            src1_q <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (state_q == S_IDLE && accept) begin
            cnt_q  <= '0;
            quo_q  <= mag1;
            rem_q  <= '0;
            b_q    <= mag2;
            src1_q <= req_src1;
            neg_q  <= s1_neg ^ s2_neg;
            rneg_q <= s1_neg;
        end else if (state_q == S_MUL) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (state_q == S_DIV) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

endmodule
